// File: rtl/instr_word_assembler_pkg.sv
// Shared types and constants for the MIPS instruction word assembler.
// Also holds the field-legality rule used when FIELD_CHECK_EN is defined.
package instr_word_assembler_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_RSV = 2'd3
   } fmt_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;

   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int TGT_W   = 26;
   localparam int WORD_W  = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCEPT = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // An opcode is legal only if it belongs to the family its format claims.
   function automatic logic fields_legal(input logic [1:0] fmt, input logic [OP_W-1:0] op);
      logic ok;
      case (fmt)
         FMT_R:   ok = (op == OP_RTYPE);
         FMT_I:   ok = !((op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL));
         FMT_J:   ok = (op == OP_J) || (op == OP_JAL);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/instr_word_assembler_pack.sv
// Combinational packer: MIPS field bundle plus format -> 32-bit instruction word.
// Fields that the selected format does not use are ignored; reserved format packs to a nop.
module instr_pack
   import instr_word_assembler_pkg::*;
(
   input  logic [1:0]         fmt_i,
   input  logic [OP_W-1:0]    op_i,
   input  logic [REG_W-1:0]   rs_i,
   input  logic [REG_W-1:0]   rt_i,
   input  logic [REG_W-1:0]   rd_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [IMM_W-1:0]   imm16_i,
   input  logic [TGT_W-1:0]   target26_i,
   output logic [WORD_W-1:0]  word_o
);

   // Field concatenation per instruction format
   always_comb begin
      word_o = 32'h0000_0000;
      case (fmt_i)
         FMT_R:   word_o = {op_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
         FMT_I:   word_o = {op_i, rs_i, rt_i, imm16_i};
         FMT_J:   word_o = {op_i, target26_i};
         default: word_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/instr_word_assembler.sv
// Packs field bundles into instruction words and writes them sequentially to memory.
// Optional macro FIELD_CHECK_EN rejects bundles whose opcode does not match the format.
module instr_word_assembler
   import instr_word_assembler_pkg::*;
#(
   parameter int AW        = 10,
   parameter int ADDR_STEP = 4
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_fmt,
   input  logic [5:0]    in_op,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [5:0]    in_funct,
   input  logic [15:0]   in_imm16,
   input  logic [25:0]   in_target26,
   input  logic          in_last,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ready,
   output logic [31:0]   mem_wdata,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   word_count,
   output logic          err
);

   localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);
   localparam logic [AW:0]   ONE  = (AW+1)'(1);

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              last_q, last_d;
   logic [AW:0]       count_q, count_d;
   logic              err_d;
   logic [WORD_W-1:0] packed_s;

   instr_pack u_pack (
      .fmt_i      (in_fmt),
      .op_i       (in_op),
      .rs_i       (in_rs),
      .rt_i       (in_rt),
      .rd_i       (in_rd),
      .shamt_i    (in_shamt),
      .funct_i    (in_funct),
      .imm16_i    (in_imm16),
      .target26_i (in_target26),
      .word_o     (packed_s)
   );

   // Next-state logic for the load / accept / write / done sequence
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      count_d = count_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACCEPT;
               addr_d  = base_addr;
               count_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCEPT: begin
            if (in_valid) begin
`ifdef FIELD_CHECK_EN
               if (!fields_legal(in_fmt, in_op)) begin
                  err_d   = 1'b1;
                  state_d = in_last ? ST_DONE : ST_ACCEPT;
               end else begin
                  wdata_d = packed_s;
                  last_d  = in_last;
                  state_d = ST_WRITE;
               end
`else
               wdata_d = packed_s;
               last_d  = in_last;
               state_d = ST_WRITE;
`endif
            end else begin
               state_d = ST_ACCEPT;
            end
         end
         ST_WRITE: begin
            if (mem_ready) begin
               addr_d  = addr_q + STEP;
               count_d = (count_q == '1) ? count_q : count_q + ONE;
               state_d = last_q ? ST_DONE : ST_ACCEPT;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any pending word
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

`ifdef FIELD_CHECK_EN
   logic err_q;

   // One-cycle pulse for a rejected bundle
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_err_s;
   assign unused_err_s = err_d;
   assign err          = 1'b0;
`endif

   assign in_ready   = (state_q == ST_ACCEPT);
   assign mem_we     = (state_q == ST_WRITE);
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_instr_word_assembler.sv
// Directed table-driven bench for instr_word_assembler plus multi-cycle corner sequences.
// Build with FIELD_CHECK_EN defined to exercise the rejection path.
module tb_instr_word_assembler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  base_addr = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_fmt = '0;
   logic [5:0]  in_op = '0;
   logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [5:0]  in_funct = '0;
   logic [15:0] in_imm16 = '0;
   logic [25:0] in_target26 = '0;
   logic        in_last = 1'b0;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic        busy, done, err;
   logic [10:0] word_count;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_cnt   = 0;

   always #5 clk = ~clk;

   instr_word_assembler #(.AW(10), .ADDR_STEP(4)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_funct(in_funct), .in_imm16(in_imm16), .in_target26(in_target26),
      .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .word_count(word_count), .err(err)
   );

   always @(posedge clk) if (mem_we && mem_ready && !reset) wr_cnt++;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] tgt;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[8];
   int   n_vec;

   function automatic vec_t mk(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                               input logic [5:0] fn, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic [31:0] e);
      vec_t v;
      v.fmt = f; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
      v.funct = fn; v.imm = imm; v.tgt = tgt; v.exp = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   task automatic do_start(input logic [9:0] b);
      @(negedge clk);
      start = 1'b1; base_addr = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input vec_t v, input logic last);
      int k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      if (!in_ready) timeout("in_ready");
      in_fmt = v.fmt; in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
      in_shamt = v.sh; in_funct = v.funct; in_imm16 = v.imm; in_target26 = v.tgt;
      in_last = last; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic expect_write(input string name, input logic [9:0] a, input logic [31:0] d,
                               input logic [10:0] cnt, input logic last);
      int k = 0;
      while (!mem_we && k < 20) begin @(negedge clk); k++; end
      if (!mem_we) timeout({name, "_we"});
      chk({name, "_addr"}, 32'(mem_addr), 32'(a));
      chk({name, "_data"}, mem_wdata, d);
      chk({name, "_err"}, 32'(err), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk({name, "_count"}, 32'(word_count), 32'(cnt));
      if (last) chk({name, "_done"}, 32'(done), 32'd1);
      else      chk({name, "_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int w0;
      vec_t v_i, v_j;

      n_vec = 0;
      tbl[n_vec++] = mk(2'd0, 6'd0,  5'd9,  5'd10, 5'd8,  5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 32'h012A4020);
      tbl[n_vec++] = mk(2'd1, 6'd8,  5'd9,  5'd8,  5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 32'h21280005);
      tbl[n_vec++] = mk(2'd2, 6'd2,  5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000);
      tbl[n_vec++] = mk(2'd0, 6'd0,  5'd0,  5'd2,  5'd1,  5'd4, 6'h00, 16'hABCD, 26'h2AAAAAA, 32'h00020900);
      tbl[n_vec++] = mk(2'd1, 6'h23, 5'd29, 5'd31, 5'd7,  5'd3, 6'h15, 16'hFFFF, 26'h1555555, 32'h8FBFFFFF);
      tbl[n_vec++] = mk(2'd2, 6'd3,  5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF);
`ifndef FIELD_CHECK_EN
      tbl[n_vec++] = mk(2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h00000000);
`endif

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_state", {20'd0, in_ready, mem_we, done, err, busy, 7'd0}, 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_count", 32'(word_count), 32'd0);

      // Table: one single-word program per vector
      for (int i = 0; i < n_vec; i++) begin
         do_start(10'(i * 8));
         send(tbl[i], 1'b1);
         expect_write($sformatf("vec%0d", i), 10'(i * 8), tbl[i].exp, 11'd1, 1'b1);
         @(negedge clk);
         chk($sformatf("vec%0d_idle", i), {30'd0, busy, done}, 32'd0);
      end

      // I then J with a start pulse in ACCEPT that must be ignored
      v_i = tbl[1]; v_j = tbl[2];
      do_start(10'h100);
      send(v_i, 1'b0);
      expect_write("ij0", 10'h100, 32'h21280005, 11'd1, 1'b0);
      start = 1'b1; base_addr = 10'h3F0;
      @(negedge clk);
      start = 1'b0;
      send(v_j, 1'b1);
      expect_write("ij1", 10'h104, 32'h08100000, 11'd2, 1'b1);

      // mem_ready while idle must not cause writes
      @(negedge clk);
      w0 = wr_cnt;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      chk("idle_ready_wr", 32'(wr_cnt - w0), 32'd0);
      chk("idle_ready_cnt", 32'(word_count), 32'd2);

      // Backpressure: 5 stalled cycles then exactly one write
      do_start(10'h040);
      send(v_i, 1'b1);
      w0 = wr_cnt;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d", c), {mem_we, in_ready, mem_addr, 20'd0},
             {1'b1, 1'b0, 10'h040, 20'd0});
         chk($sformatf("bp%0d_data", c), mem_wdata, 32'h21280005);
         @(negedge clk);
      end
      expect_write("bp_rel", 10'h040, 32'h21280005, 11'd1, 1'b1);
      chk("bp_one_write", 32'(wr_cnt - w0), 32'd1);

      // Address wrap at the top of the 10-bit space
      do_start(10'h3FC);
      send(tbl[0], 1'b0);
      expect_write("wrap0", 10'h3FC, 32'h012A4020, 11'd1, 1'b0);
      send(tbl[3], 1'b1);
      expect_write("wrap1", 10'h000, 32'h00020900, 11'd2, 1'b1);

      // Reset during a stalled write
      do_start(10'h080);
      send(tbl[0], 1'b0);
      expect_write("pre_rst", 10'h080, 32'h012A4020, 11'd1, 1'b0);
      send(v_i, 1'b0);
      chk("pre_rst_we", 32'(mem_we), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_wr_state", {29'd0, mem_we, busy, done}, 32'd0);
      chk("rst_wr_count", 32'(word_count), 32'd0);
      do_start(10'h200);
      send(v_j, 1'b1);
      expect_write("post_rst", 10'h200, 32'h08100000, 11'd1, 1'b1);

`ifdef FIELD_CHECK_EN
      // Illegal R-type opcode: consumed with err, address not advanced
      do_start(10'h0C0);
      send(mk(2'd0, 6'd8, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 32'h0), 1'b0);
      chk("rej_err", {29'd0, err, mem_we, in_ready}, 32'b101);
      @(negedge clk);
      chk("rej_err_clear", 32'(err), 32'd0);
      send(tbl[0], 1'b1);
      expect_write("rej_next", 10'h0C0, 32'h012A4020, 11'd1, 1'b1);
      // Reserved format with last ends the program without a write
      do_start(10'h0D0);
      w0 = wr_cnt;
      send(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 32'h0), 1'b1);
      chk("rej_last", {29'd0, err, done, mem_we}, 32'b110);
      chk("rej_last_wr", 32'(wr_cnt - w0), 32'd0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/instr_word_assembler.md
Name: instr_word_assembler

Overview:
- Inverse of the instruction field decoder: packs MIPS field bundles (R/I/J formats) into 32-bit instruction words.
- Writes the packed words sequentially into instruction memory through a handshaked write port.
- Sits between the program loader/testbench stimulus and the instruction memory; fills memory before the CPU runs.

Parameters:
- AW, 10, instruction memory address width (byte address).
- ADDR_STEP, 4, address increment per written word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; loads base_addr and clears word_count. Honoured only in IDLE.
- base_addr  in  AW  first write address.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  assembler can accept a bundle.
- in_fmt  in  2  format: 0=R, 1=I, 2=J, 3=reserved.
- in_op  in  6  opcode.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_shamt  in  5  shift amount.
- in_funct  in  6  function code.
- in_imm16  in  16  immediate.
- in_target26  in  26  jump target.
- in_last  in  1  final bundle of the program.
- mem_we  out  1  write request.
- mem_addr  out  AW  write address.
- mem_wdata  out  32  packed instruction.
- mem_ready  in  1  memory accepts write this cycle.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse after the last word is written.
- word_count  out  AW+1  words written since start.
- err  out  1  one-cycle pulse on a rejected bundle; tied 0 when the optional feature is off.

Behaviour:
- Reset values: state IDLE; in_ready, mem_we, done, err, busy = 0; mem_addr, mem_wdata, word_count = 0. Reset wins over all other inputs.
- Reset mid-write: mem_we drops the cycle after reset is sampled; the pending word is discarded.
- FSM states:
  - IDLE: start -> ACCEPT; mem_addr <= base_addr; word_count <= 0.
  - ACCEPT: in_ready = 1. On in_valid: latch the packed word into mem_wdata and latch in_last -> WRITE.
  - WRITE: mem_we = 1; address and data are held stable until mem_ready. On mem_ready: mem_addr += ADDR_STEP (wraps modulo 2^AW); word_count += 1 (saturates at all-ones); next state is DONE if last was latched, else ACCEPT.
  - DONE: done = 1 for one cycle -> IDLE.
- Packing:
  - R: {op, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm16}.
  - J: {op, target26}.
  - fmt 3: 32'h00000000 (nop).
  - Fields not used by the selected format are ignored.
- Latency: bundle accepted at edge N -> mem_we high after edge N. Minimum 2 cycles per word.
- mem_ready while mem_we = 0 is ignored. start outside IDLE is ignored. in_ready is never high in WRITE, so there is no simultaneous accept and write.
- Address wrap: base 0x3FC with AW=10 -> second word written to 0x000.

Optional Feature:
- Macro FIELD_CHECK_EN.
- Defined: in ACCEPT, a bundle is rejected (consumed, not written, err pulses 1 cycle, state stays ACCEPT) if any of:
  - fmt=R and op!=0
  - fmt=J and op not in {2,3}
  - fmt=I and op in {0,2,3}
  - fmt=3
- A rejected bundle with in_last=1 -> DONE with no write.
- Undefined: no checks; err is tied 0.

Decomposition:
- Shared package:
  - format enum (FMT_R / FMT_I / FMT_J / FMT_RSV).
  - opcode constants OP_RTYPE=0, OP_J=2, OP_JAL=3.
  - field width constants.
  - FSM state enum.
- Sub-module instr_pack: purely combinational fields+fmt -> 32-bit word. Reusable by the bench as a reference model.

Test Plan:
- R-type: start base 0x000; bundle R op0 rs9 rt10 rd8 shamt0 funct0x20, last=1 -> mem_wdata 0x012A4020 @ 0x000, word_count 1, done pulse.
- I+J sequence: base 0x100; I op8 rs9 rt8 imm5, then J op2 target 0x0100000 with last -> 0x21280005 @ 0x100, 0x08100000 @ 0x104, word_count 2.
- Backpressure: hold mem_ready=0 for 5 cycles -> mem_we, mem_addr and mem_wdata stable, in_ready 0. Release -> exactly one write.
- Wrap: AW=10, base 0x3FC, two words -> addresses 0x3FC then 0x000.
- Reset in WRITE with mem_ready=0 -> next cycle mem_we=0, busy=0, word_count=0. A later start works normally.
- FIELD_CHECK_EN: R bundle with op=8 -> err pulse, no mem_we, in_ready stays 1. Next valid bundle is written at the unadvanced address.
